// File: rtl/icache.sv
// Direct-mapped instruction cache: one-cycle hits, word-by-word line refill
// from the memory controller, and mispredict squash of the pending response.
module icache #(
  parameter int INDEX_W = 6,
  parameter int OFF_W   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        IF_pc_sgn,
  input  logic [31:0] IF_pc,
  output logic        IF_ins_sgn,
  output logic [31:0] IF_ins,
  input  logic        ROB_jp_wrong,
  output logic        MC_req,
  output logic [31:0] MC_addr,
  input  logic        MC_done,
  input  logic [31:0] MC_data
);

  localparam int LINES  = 1 << INDEX_W;
  localparam int WORDS  = 1 << OFF_W;
  localparam int TAG_LO = INDEX_W + OFF_W + 2;
  localparam int TAG_W  = 32 - TAG_LO;
  localparam logic [31:0] LINE_MASK = {{(30 - OFF_W){1'b0}}, {(OFF_W + 2){1'b1}}};

  typedef enum logic {IDLE, REFILL} state_t;

  state_t             state_q;
  logic [OFF_W-1:0]   cnt_q;
  logic [OFF_W-1:0]   off_q;
  logic [31:0]        base_q;
  logic               squash_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_q  [LINES];
  logic [31:0]        data_q [LINES][WORDS];

  logic [OFF_W-1:0]   req_off_d;
  logic [INDEX_W-1:0] req_idx_d;
  logic [TAG_W-1:0]   req_tag_d;
  logic [INDEX_W-1:0] fill_idx_d;
  logic [TAG_W-1:0]   fill_tag_d;
  logic               hit_d;
  logic               last_d;
  logic               take_d;
  logic [31:0]        fill_word_d;

  assign req_off_d  = IF_pc[OFF_W+1:2];
  assign req_idx_d  = IF_pc[TAG_LO-1:OFF_W+2];
  assign req_tag_d  = IF_pc[31:TAG_LO];
  assign fill_idx_d = base_q[TAG_LO-1:OFF_W+2];
  assign fill_tag_d = base_q[31:TAG_LO];
  assign hit_d      = valid_q[req_idx_d] && (tag_q[req_idx_d] == req_tag_d);
  assign last_d     = (cnt_q == {OFF_W{1'b1}});
  assign take_d     = rdy && (state_q == REFILL) && MC_done;
  // The requested word may be the one arriving right now rather than one already stored.
  assign fill_word_d = (off_q == cnt_q) ? MC_data : data_q[fill_idx_d][off_q];

  assign MC_req  = (state_q == REFILL);
  assign MC_addr = base_q + {{(30 - OFF_W){1'b0}}, cnt_q, 2'b00};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      off_q      <= '0;
      base_q     <= '0;
      squash_q   <= 1'b0;
      valid_q    <= '0;
      IF_ins_sgn <= 1'b0;
      IF_ins     <= '0;
    end else if (rdy) begin
      IF_ins_sgn <= 1'b0;
      case (state_q)
        IDLE: begin
          squash_q <= 1'b0;
          if (IF_pc_sgn && !ROB_jp_wrong) begin
            if (hit_d) begin
              IF_ins     <= data_q[req_idx_d][req_off_d];
              IF_ins_sgn <= 1'b1;
            end else begin
              base_q  <= IF_pc & ~LINE_MASK;
              off_q   <= req_off_d;
              cnt_q   <= '0;
              state_q <= REFILL;
            end
          end
        end
        REFILL: begin
          if (ROB_jp_wrong) squash_q <= 1'b1;
          if (MC_done) begin
            cnt_q <= cnt_q + 1'b1;
            if (last_d) begin
              valid_q[fill_idx_d] <= 1'b1;
              IF_ins              <= fill_word_d;
              IF_ins_sgn          <= !(squash_q || ROB_jp_wrong);
              squash_q            <= 1'b0;
              state_q             <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Tag and data storage carry no reset; valid_q alone decides whether a line is usable.
  always_ff @(posedge clk) begin
    if (take_d) begin
      data_q[fill_idx_d][cnt_q] <= MC_data;
      if (last_d) tag_q[fill_idx_d] <= fill_tag_d;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed vectors and sequences plus randomized fetches
// checked against a line-level cache model and a word-addressed memory function.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        IF_pc_sgn;
  logic [31:0] IF_pc;
  logic        IF_ins_sgn;
  logic [31:0] IF_ins;
  logic        ROB_jp_wrong;
  logic        MC_req;
  logic [31:0] MC_addr;
  logic        MC_done;
  logic [31:0] MC_data;

  icache #(.INDEX_W(6), .OFF_W(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .IF_pc_sgn(IF_pc_sgn), .IF_pc(IF_pc),
    .IF_ins_sgn(IF_ins_sgn), .IF_ins(IF_ins),
    .ROB_jp_wrong(ROB_jp_wrong),
    .MC_req(MC_req), .MC_addr(MC_addr),
    .MC_done(MC_done), .MC_data(MC_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int mc_lat   = 3;
  int wait_cnt = 0;
  logic [31:0] addr_log[$];

  bit          m_valid [64];
  logic [21:0] m_tag   [64];

  typedef struct {
    logic [31:0] pc;
    logic        squash;
    logic        exp_sgn;
    logic        exp_req;
  } vec_t;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000 ^ {a[15:0], a[31:16]};
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    return m_valid[pc[9:4]] && (m_tag[pc[9:4]] == pc[31:10]);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory controller: answers each word mc_lat enabled cycles after MC_req/MC_addr are seen.
  initial begin
    MC_done = 1'b0;
    MC_data = '0;
    forever begin
      @(posedge clk);
      #2;
      MC_done = 1'b0;
      if (!rst || !MC_req) begin
        wait_cnt = 0;
      end else if (rdy) begin
        if (wait_cnt + 1 >= mc_lat) begin
          MC_done = 1'b1;
          MC_data = mem_word(MC_addr);
          addr_log.push_back(MC_addr);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic do_fetch(input logic [31:0] pc, input int lat, input int squash_at,
                          input int stall_at, input bit hold_req);
    bit exp_hit;
    bit squashed;
    bit stalled;
    bit done;
    logic [31:0] base;
    logic [31:0] saved;
    exp_hit  = model_hit(pc);
    base     = pc & 32'hFFFF_FFF0;
    mc_lat   = lat;
    squashed = 0;
    stalled  = 0;
    done     = 0;
    addr_log.delete();
    IF_pc        = pc;
    IF_pc_sgn    = 1'b1;
    ROB_jp_wrong = 1'b0;
    tick();
    if (hold_req) IF_pc = 32'h0000_0100;
    else IF_pc_sgn = 1'b0;
    if (exp_hit) begin
      check("hit_sgn", 32'(IF_ins_sgn), 32'd1);
      check("hit_data", IF_ins, mem_word(pc));
      check("hit_noreq", 32'(MC_req), 32'd0);
    end else begin
      check("miss_req", 32'(MC_req), 32'd1);
      for (int c = 0; c < 200 && !done; c++) begin
        if (hold_req && addr_log.size() >= 3) IF_pc_sgn = 1'b0;
        if (squash_at >= 0 && !squashed && addr_log.size() == squash_at) begin
          ROB_jp_wrong = 1'b1;
          squashed = 1;
        end
        if (stall_at >= 0 && !stalled && addr_log.size() == stall_at) begin
          stalled = 1;
          saved   = MC_addr;
          rdy     = 1'b0;
          for (int k = 0; k < 5; k++) begin
            tick();
            check("stall_addr", MC_addr, saved);
            check("stall_req", 32'(MC_req), 32'd1);
          end
          rdy = 1'b1;
        end
        tick();
        ROB_jp_wrong = 1'b0;
        if (!MC_req) done = 1;
      end
      if (!done) begin
        n_checks++;
        n_fail++;
        $display("FAIL refill_timeout: pc %h, MC_req still %b", pc, MC_req);
      end else begin
        check("resp_sgn", 32'(IF_ins_sgn), squashed ? 32'd0 : 32'd1);
        if (!squashed) check("resp_data", IF_ins, mem_word(pc));
      end
      check("mc_words", 32'(addr_log.size()), 32'd4);
      for (int k = 0; k < 4 && k < addr_log.size(); k++)
        check("mc_addr", addr_log[k], base + 32'(4 * k));
      m_valid[pc[9:4]] = 1'b1;
      m_tag[pc[9:4]]   = pc[31:10];
    end
    IF_pc_sgn = 1'b0;
    tick();
    check("pulse_end", 32'(IF_ins_sgn), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    rst          = 1'b0;
    rdy          = 1'b1;
    IF_pc_sgn    = 1'b0;
    IF_pc        = '0;
    ROB_jp_wrong = 1'b0;
    model_clear();
    vecs[0] = '{pc: 32'h4,   squash: 1'b0, exp_sgn: 1'b1, exp_req: 1'b0};
    vecs[1] = '{pc: 32'h8,   squash: 1'b0, exp_sgn: 1'b1, exp_req: 1'b0};
    vecs[2] = '{pc: 32'hC,   squash: 1'b0, exp_sgn: 1'b1, exp_req: 1'b0};
    vecs[3] = '{pc: 32'h0,   squash: 1'b0, exp_sgn: 1'b1, exp_req: 1'b0};
    vecs[4] = '{pc: 32'h8,   squash: 1'b1, exp_sgn: 1'b0, exp_req: 1'b0};
    vecs[5] = '{pc: 32'h4,   squash: 1'b0, exp_sgn: 1'b1, exp_req: 1'b0};
    vecs[6] = '{pc: 32'h200, squash: 1'b1, exp_sgn: 1'b0, exp_req: 1'b0};
    vecs[7] = '{pc: 32'hC,   squash: 1'b0, exp_sgn: 1'b1, exp_req: 1'b0};
    repeat (3) tick();
    check("rst_sgn", 32'(IF_ins_sgn), 32'd0);
    check("rst_ins", IF_ins, 32'd0);
    check("rst_req", 32'(MC_req), 32'd0);
    check("rst_addr", MC_addr, 32'd0);
    rst = 1'b1;
    tick();

    // Cold miss with the fetcher holding a different request during the refill.
    do_fetch(32'h0, 3, -1, -1, 1'b1);

    // Back-to-back hits, squashed hit and squashed miss, one per cycle.
    for (int i = 0; i < 8; i++) begin
      IF_pc        = vecs[i].pc;
      IF_pc_sgn    = 1'b1;
      ROB_jp_wrong = vecs[i].squash;
      tick();
      check("vec_sgn", 32'(IF_ins_sgn), 32'(vecs[i].exp_sgn));
      if (vecs[i].exp_sgn) check("vec_data", IF_ins, mem_word(vecs[i].pc));
      check("vec_req", 32'(MC_req), 32'(vecs[i].exp_req));
    end
    IF_pc_sgn    = 1'b0;
    ROB_jp_wrong = 1'b0;
    tick();

    // Conflict eviction of line 0 and its refill.
    do_fetch(32'h400, 2, -1, -1, 1'b0);
    do_fetch(32'h0, 1, -1, -1, 1'b0);

    // Squash during the third word; line still installed.
    do_fetch(32'h10, 3, 2, -1, 1'b0);
    do_fetch(32'h14, 1, -1, -1, 1'b0);

    // Five-cycle stall mid-refill.
    do_fetch(32'h28, 2, -1, 2, 1'b0);

    // Asynchronous reset between clock edges during a refill.
    mc_lat = 3;
    addr_log.delete();
    IF_pc = 32'h30;
    IF_pc_sgn = 1'b1;
    tick();
    IF_pc_sgn = 1'b0;
    repeat (4) tick();
    check("pre_rst_req", 32'(MC_req), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_req", 32'(MC_req), 32'd0);
    check("async_rst_addr", MC_addr, 32'd0);
    model_clear();
    tick();
    tick();
    rst = 1'b1;
    tick();
    do_fetch(32'h0, 2, -1, -1, 1'b0);
    do_fetch(32'h34, 1, -1, -1, 1'b0);

    // Randomized fetches over a small footprint so hits, misses and conflicts all occur.
    for (int t = 0; t < 40; t++) begin
      logic [31:0] pc;
      int sq;
      int st;
      pc = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
      sq = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
      st = (sq < 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : -1;
      do_fetch(pc, int'($urandom_range(1, 4)), sq, st, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped instruction cache serving the instruction fetcher's one-outstanding fetch interface and refilling lines from the memory controller one 32-bit word at a time. It accepts a fetch PC, returns the instruction one cycle later on a hit, or runs a line refill on a miss and then returns the word. It sits between the instruction fetcher and the memory controller's instruction port, and honours ROB mispredict squashes.

## Interface
- INDEX_W, 6: index bits; 2^INDEX_W lines.
- OFF_W, 2: word-offset bits; 2^OFF_W words per line.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- rdy  in  1  global enable; when 0, no state or register changes.
- IF_pc_sgn  in  1  fetch request valid.
- IF_pc  in  32  fetch byte address; bits [1:0] are 0.
- IF_ins_sgn  out  1  instruction valid, one-cycle pulse.
- IF_ins  out  32  returned instruction.
- ROB_jp_wrong  in  1  mispredict squash.
- MC_req  out  1  word-read request to the memory controller.
- MC_addr  out  32  word address of the request.
- MC_done  in  1  one-cycle pulse: MC_data is valid and the request is complete.
- MC_data  in  32  returned word.

## Operation
- Address split:
  - offset = IF_pc[OFF_W+1:2]
  - index = IF_pc[INDEX_W+OFF_W+1:OFF_W+2]
  - tag = the remaining upper bits.
- Arrays: valid[2^INDEX_W] is cleared by reset. Tag and data arrays are not reset.
- FSM has two states, IDLE and REFILL.
- IDLE, IF_pc_sgn=1, ROB_jp_wrong=0:
  - Hit: IF_ins <= data[index][offset], IF_ins_sgn <= 1. Stay IDLE.
  - Miss: latch pc, set line base = pc with the offset and [1:0] bits cleared, set word counter cnt=0, go to REFILL.
- IDLE accepts a request in every cycle, including the cycle in which IF_ins_sgn is high. Back-to-back hits give one response per cycle.
- REFILL:
  - MC_req = 1 (combinational from state); MC_addr = base + 4*cnt.
  - IF_pc_sgn is ignored.
  - On MC_done: data[index][cnt] <= MC_data, then cnt++.
  - On the MC_done with cnt = 2^OFF_W−1:
    - valid[index] <= 1, tag[index] <= latched tag.
    - IF_ins <= the requested word, taken from MC_data if offset = cnt, else from the array word written earlier.
    - IF_ins_sgn <= 1 unless a squash is pending.
    - Go to IDLE.
- Squash (ROB_jp_wrong=1):
  - In IDLE: the request presented in that cycle is dropped, and no response is scheduled for the next cycle.
  - In REFILL: set squash_pending. The refill still runs to completion (an MC transaction is never aborted) and the line is installed. The final response is suppressed; squash_pending clears on return to IDLE.
  - An IF_ins_sgn already high during the squash cycle is not retracted; the fetcher prioritises the squash.
- MC_done while MC_req=0 is ignored.
- Default each cycle: IF_ins_sgn <= 0 unless set above. IF_ins holds its last value.

## Timing
- Reset (rst=0, asynchronous):
  - IF_ins_sgn=0, IF_ins=0, MC_req=0, MC_addr=0.
  - State IDLE, cnt=0, squash_pending=0, all valid bits 0.
  - Reset takes effect immediately, including mid-refill. A partial line is never marked valid.
- Hit latency: request at cycle T, IF_ins_sgn=1 at T+1.
- Miss latency: request at T, MC_req=1 from T+1. The response arrives the cycle after the last MC_done.
- Between words: MC_addr advances in the cycle after each MC_done, and MC_req stays high. The memory controller starts the next word from the new address.
- rdy=0: all registers hold, MC_req/MC_addr stable. The memory controller does not assert MC_done while rdy=0.
- Wrap: cnt wraps to 0 at the end of a line. Address arithmetic is 32-bit; base + 4*cnt never crosses a line.

## Test plan
- Cold miss: reset, request 0x0000_0000 with MC latency 3 cycles.
  - Required: MC_addr sequence 0x0, 0x4, 0x8, 0xC.
  - Required: a single IF_ins_sgn pulse carrying word@0x0, one cycle after the fourth MC_done; IF_pc_sgn ignored during the refill.
- Hit streaming: after the fill, request 0x4, 0x8, 0xC on consecutive cycles.
  - Required: IF_ins_sgn high for 3 consecutive cycles with the matching words; MC_req stays 0.
- Conflict eviction: request 0x400 (index 0, tag 1).
  - Required: refill 0x400–0x40C.
  - Required: a following request to 0x0 misses and refills again.
- Squash mid-refill: ROB_jp_wrong pulse during the third word.
  - Required: the fourth word is still fetched and no IF_ins_sgn is produced.
  - Required: a later request to the same line hits in 1 cycle.
- rdy stall: rdy=0 for 5 cycles mid-refill.
  - Required: MC_addr, cnt and state are unchanged; the refill resumes correctly afterwards.
- Async reset mid-refill: rst=0 between clock edges.
  - Required: MC_req drops to 0 immediately.
  - Required: after release, a request to 0x0 misses (the valid bit was cleared).
